// File: rtl/pmp_csr_file.sv
// M-mode CSR file for pmpcfg/pmpaddr state with lock and WARL handling.
// Each access is taken in IDLE and is acknowledged one cycle later from RESP.
module pmp_csr_file #(
    parameter int unsigned PMP_CNT = 16,
    parameter int unsigned VLEN    = 31,
    parameter logic [1:0]  M_MODE  = 2'b11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           csr_req,
    input  logic                           csr_we,
    input  logic [11:0]                    csr_addr,
    input  logic [31:0]                    csr_wdata,
    input  logic [1:0]                     csr_prv,
    output logic                           csr_ack,
    output logic [31:0]                    csr_rdata,
    output logic                           csr_err,
    output logic                           pmp_update,
    output logic [PMP_CNT*8-1:0]           io_pmpcfg,
    output logic [PMP_CNT*(VLEN+1)-1:0]    io_pmpaddr
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [4:0] CFG_WORDS = 5'(PMP_CNT / 4);
    localparam logic [4:0] ADDR_REGS = 5'(PMP_CNT);

    state_t                           state_q, state_d;
    logic [PMP_CNT-1:0][7:0]          cfg_q, cfg_d;
    logic [PMP_CNT-1:0][VLEN:0]       addr_q, addr_d;
    logic                             ack_q, ack_d;
    logic                             err_q, err_d;
    logic                             upd_q, upd_d;
    logic [31:0]                      rdata_q, rdata_d;

    logic                             cfg_hit, addr_hit, legal;
    logic [PMP_CNT-1:0]               addr_lock;
    logic [7:0]                       wbyte;

    assign cfg_hit  = (csr_addr[11:4] == 8'h3A) && ({1'b0, csr_addr[3:0]} < CFG_WORDS);
    assign addr_hit = (csr_addr[11:4] == 8'h3B) && ({1'b0, csr_addr[3:0]} < ADDR_REGS);
    assign legal    = (csr_prv == M_MODE) && (cfg_hit || addr_hit);

    // pmpaddr i is frozen by its own lock, or by a locked TOR entry i+1 using it as base.
    always_comb begin
        addr_lock = '0;
        for (int unsigned i = 0; i < PMP_CNT; i++) begin
            addr_lock[i] = cfg_q[i][7];
        end
        for (int unsigned i = 0; i + 1 < PMP_CNT; i++) begin
            if (cfg_q[i+1][7] && (cfg_q[i+1][4:3] == 2'b01)) begin
                addr_lock[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        addr_d  = addr_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        upd_d   = 1'b0;
        rdata_d = '0;
        wbyte   = '0;
        unique case (state_q)
            IDLE: begin
                if (csr_req) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    if (!legal) begin
                        err_d = 1'b1;
                    end else if (csr_we) begin
                        for (int unsigned e = 0; e < PMP_CNT; e++) begin
                            if (cfg_hit && ((e >> 2) == 32'(csr_addr[3:0])) && !cfg_q[e][7]) begin
                                wbyte = csr_wdata[8*(e & 3) +: 8] & 8'h9F;
                                if (wbyte[1:0] == 2'b10) begin
                                    wbyte[1:0] = 2'b00;
                                end
                                cfg_d[e] = wbyte;
                            end
                            if (addr_hit && (e == 32'(csr_addr[3:0])) && !addr_lock[e]) begin
                                addr_d[e] = csr_wdata[VLEN:0];
                            end
                        end
                        upd_d = (cfg_d != cfg_q) || (addr_d != addr_q);
                    end else begin
                        for (int unsigned e = 0; e < PMP_CNT; e++) begin
                            if (cfg_hit && ((e >> 2) == 32'(csr_addr[3:0]))) begin
                                rdata_d[8*(e & 3) +: 8] = cfg_q[e];
                            end
                            if (addr_hit && (e == 32'(csr_addr[3:0]))) begin
                                rdata_d[VLEN:0] = addr_q[e];
                            end
                        end
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
            rdata_q <= rdata_d;
        end
    end

    assign csr_ack    = ack_q;
    assign csr_err    = err_q;
    assign csr_rdata  = rdata_q;
    assign pmp_update = upd_q;
    assign io_pmpcfg  = cfg_q;
    assign io_pmpaddr = addr_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed vector bench for pmp_csr_file: lock, TOR, WARL, error and reset behaviour.
module tb_pmp_csr_file;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          csr_req = 1'b0;
    logic          csr_we = 1'b0;
    logic [11:0]   csr_addr = '0;
    logic [31:0]   csr_wdata = '0;
    logic [1:0]    csr_prv = 2'b11;
    logic          csr_ack;
    logic [31:0]   csr_rdata;
    logic          csr_err;
    logic          pmp_update;
    logic [127:0]  io_pmpcfg;
    logic [511:0]  io_pmpaddr;

    int tests = 0;
    int fails = 0;

    pmp_csr_file #(.PMP_CNT(16), .VLEN(31), .M_MODE(2'b11)) dut (
        .clk(clk), .rst(rst), .csr_req(csr_req), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_prv(csr_prv),
        .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_err(csr_err),
        .pmp_update(pmp_update), .io_pmpcfg(io_pmpcfg), .io_pmpaddr(io_pmpaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [1:0]  prv;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        logic        upd;
    } vec_t;

    vec_t vecs[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void rd(logic [11:0] a, logic [31:0] exp, logic e = 1'b0, logic [1:0] p = 2'b11);
        vecs.push_back('{1'b0, a, 32'h0, p, 1'b1, exp, e, 1'b0});
    endfunction

    function automatic void wr(logic [11:0] a, logic [31:0] d, logic u, logic e = 1'b0, logic [1:0] p = 2'b11);
        vecs.push_back('{1'b1, a, d, p, e, 32'h0, e, u});
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        chk($sformatf("v%0d_ack_before", idx), 32'(csr_ack), 32'h0);
        csr_req = 1'b1; csr_we = v.we; csr_addr = v.addr; csr_wdata = v.wdata; csr_prv = v.prv;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ack", idx), 32'(csr_ack), 32'h1);
        chk($sformatf("v%0d_err", idx), 32'(csr_err), 32'(v.err));
        chk($sformatf("v%0d_update", idx), 32'(pmp_update), 32'(v.upd));
        if (v.chk_rd) chk($sformatf("v%0d_rdata", idx), csr_rdata, v.rdata);
        @(negedge clk);
        csr_req = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ack_drop", idx), 32'(csr_ack), 32'h0);
        chk($sformatf("v%0d_update_pulse", idx), 32'(pmp_update), 32'h0);
    endtask

    initial begin
        rd(12'h3A0, 32'h0);
        rd(12'h3B5, 32'h0);
        wr(12'h3A0, 32'h9F0F6203, 1'b1);
        rd(12'h3A0, 32'h9F0F0003);
        // entry3 is locked NAPOT: only its own pmpaddr is frozen
        wr(12'h3B2, 32'h00001234, 1'b1);
        rd(12'h3B2, 32'h00001234);
        wr(12'h3B3, 32'h00005555, 1'b0);
        rd(12'h3B3, 32'h0);
        wr(12'h3B4, 32'h0000ABCD, 1'b1);
        rd(12'h3B4, 32'h0000ABCD);
        wr(12'h3B4, 32'h0000ABCD, 1'b0);
        // entry5 locked TOR freezes pmpaddr4 and pmpaddr5
        wr(12'h3A1, 32'h00008900, 1'b1);
        rd(12'h3A1, 32'h00008900);
        wr(12'h3B4, 32'h0000FFFF, 1'b0);
        rd(12'h3B4, 32'h0000ABCD);
        wr(12'h3B5, 32'h00000001, 1'b0);
        rd(12'h3B5, 32'h0);
        wr(12'h3A0, 32'h00000000, 1'b1);
        rd(12'h3A0, 32'h9F000000);
        wr(12'h3A1, 32'hFFFFFFFF, 1'b1);
        rd(12'h3A1, 32'h9F9F899F);
        rd(12'h3B0, 32'h0, 1'b1, 2'b00);
        wr(12'h3B0, 32'h0000FFFF, 1'b0, 1'b1, 2'b00);
        rd(12'h3B0, 32'h0);
        rd(12'h3C0, 32'h0, 1'b1);
        wr(12'h3A4, 32'h01010101, 1'b0, 1'b1);
        wr(12'h3C0, 32'h01010101, 1'b0, 1'b1);
        wr(12'h3A2, 32'h00006006, 1'b1);
        rd(12'h3A2, 32'h00000004);
        wr(12'h3BF, 32'hDEADBEEF, 1'b1);
        rd(12'h3BF, 32'hDEADBEEF);

        repeat (2) @(negedge clk);
        chk("reset_ack", 32'(csr_ack), 32'h0);
        chk("reset_update", 32'(pmp_update), 32'h0);
        chk("reset_cfg0", io_pmpcfg[31:0], 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        chk("io_cfg_word0", io_pmpcfg[31:0], 32'h9F000000);
        chk("io_cfg_word1", io_pmpcfg[63:32], 32'h9F9F899F);
        chk("io_addr4", io_pmpaddr[4*32 +: 32], 32'h0000ABCD);
        chk("io_addr15", io_pmpaddr[15*32 +: 32], 32'hDEADBEEF);

        // Reset lands right after a write is sampled: ack is cancelled, all state clears
        @(negedge clk);
        csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'h3B6; csr_wdata = 32'h00000077; csr_prv = 2'b11;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_ack_cancel", 32'(csr_ack), 32'h0);
        @(negedge clk);
        csr_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_ack_held", 32'(csr_ack), 32'h0);
        chk("rst_update", 32'(pmp_update), 32'h0);
        chk("rst_cfg_lo", io_pmpcfg[63:0] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
        chk("rst_cfg_hi", io_pmpcfg[127:64] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
        chk("rst_addr_all", io_pmpaddr == '0 ? 32'h0 : 32'h1, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        vecs.delete();
        rd(12'h3A0, 32'h0);
        rd(12'h3B6, 32'h0);
        wr(12'h3B5, 32'h00000042, 1'b1);
        rd(12'h3B5, 32'h00000042);
        foreach (vecs[i]) run_vec(vecs[i], 100 + i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
